// File: rtl/div16u_seq.sv
// div16u_seq: radix-2 restoring sequential unsigned divider, A = Q*B + R with 0 <= R < B
module div16u_seq #(
  parameter int WA = 16,
  parameter int WB = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WA-1:0] A,
  input  logic [WB-1:0] B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WA-1:0] Q,
  output logic [WB-1:0] R,
  output logic          dz
);
  localparam int CW = $clog2(WA + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t        r_state, w_next;
  logic [WA-1:0] r_q, w_qn;
  logic [WB-1:0] r_b;
  logic [WB:0]   r_p, w_t, w_d, w_pn;
  logic [CW-1:0] r_cnt;
  logic          w_ge, w_acc, w_last;
  always_comb begin
    w_t = (WB+1)'({r_p, r_q[WA-1]});
    w_ge = w_t >= {1'b0, r_b};
    w_d = w_t - {1'b0, r_b};
    w_pn = w_ge ? w_d : w_t;
    w_qn = {r_q[WA-2:0], w_ge};
    w_acc = in_valid && r_state == IDLE;
    w_last = r_cnt == CW'(1);
    in_ready = r_state == IDLE;
    out_valid = r_state == DONE;
    w_next = (r_state == IDLE) ? (in_valid ? ((B == '0) ? DONE : CALC) : IDLE) :
             (r_state == CALC) ? (w_last ? DONE : CALC) :
             (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_q <= '0;
      r_b <= '0;
      r_p <= '0;
      r_cnt <= '0;
      Q <= '0;
      R <= '0;
      dz <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_q <= A;
        r_b <= B;
        r_p <= '0;
        r_cnt <= CW'(WA);
        dz <= B == '0;
        if (B == '0) begin
          Q <= '1;
          R <= A[WB-1:0];
        end
      end else if (r_state == CALC) begin
        r_p <= w_pn;
        r_q <= w_qn;
        r_cnt <= r_cnt - CW'(1);
        if (w_last) begin
          Q <= w_qn;
          R <= w_pn[WB-1:0];
        end
      end
    end
  end
endmodule
